xadc_sample_packetizer: RTL and testbench



---
 rtl/xadc_packet_pkg.sv | 26 ++
 rtl/axis_sample_hold.sv | 46 ++++
 rtl/xadc_sample_packetizer.sv | 147 ++++++++++++++
 tb/tb_xadc_sample_packetizer.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/xadc_packet_pkg.sv
// Shared types and sizing for the XADC sample packetizer.
// Define XADC_PACKET_CHECKSUM_EN to append an XOR checksum byte to every packet.
package xadc_packet_pkg;

    localparam int unsigned SEQ_WIDTH    = 8;
    localparam int unsigned SAMPLE_WIDTH = 16;
    localparam int unsigned BYTE_WIDTH   = 8;

`ifdef XADC_PACKET_CHECKSUM_EN
    localparam int unsigned PACKET_BYTES = 6;
`else
    localparam int unsigned PACKET_BYTES = 5;
`endif

    localparam int unsigned BYTE_IDX_W = $clog2(PACKET_BYTES);

    typedef logic [BYTE_IDX_W-1:0] byte_idx_t;

    typedef enum logic [0:0] {
        COLLECT = 1'b0,
        SEND    = 1'b1
    } packetizer_state_t;

    localparam byte_idx_t LAST_IDX = byte_idx_t'(PACKET_BYTES - 1);

endpackage

// File: rtl/axis_sample_hold.sv
// One-entry AXIS holding register: accepts a sample while empty, holds it until cleared.
module axis_sample_hold
    import xadc_packet_pkg::*;
#(
    parameter int unsigned WIDTH = SAMPLE_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_tvalid,
    output logic             s_tready,
    input  logic [WIDTH-1:0] s_tdata,
    input  logic             clear,
    output logic             full,
    output logic [WIDTH-1:0] data,
    output logic             take_c
);

    logic full_n;

    // Clear only arrives while full, so it never races a capture.
    always_comb begin
        take_c = s_tvalid & s_tready;
        full_n = full;
        if (clear) begin
            full_n = 1'b0;
        end else if (take_c) begin
            full_n = 1'b1;
        end
    end

    // Ready is registered from next-full so it is low throughout reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full     <= 1'b0;
            s_tready <= 1'b0;
            data     <= '0;
        end else begin
            full     <= full_n;
            s_tready <= ~full_n;
            if (take_c) begin
                data <= s_tdata;
            end
        end
    end

endmodule

// File: rtl/xadc_sample_packetizer.sv
// Pairs voltage/current samples and emits them as a sequence-numbered byte packet.
// Define XADC_PACKET_CHECKSUM_EN to append an XOR checksum byte carrying tlast.
module xadc_sample_packetizer
    import xadc_packet_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    voltage_tvalid,
    output logic                    voltage_tready,
    input  logic [SAMPLE_WIDTH-1:0] voltage_tdata,
    input  logic                    current_tvalid,
    output logic                    current_tready,
    input  logic [SAMPLE_WIDTH-1:0] current_tdata,
    output logic                    packet_tvalid,
    input  logic                    packet_tready,
    output logic [BYTE_WIDTH-1:0]   packet_tdata,
    output logic                    packet_tlast,
    output logic                    packet_tkeep,
    output logic                    packet_tid,
    output logic                    packet_tdest,
    output logic                    packet_tuser
);

    packetizer_state_t       state, state_n;
    logic [SEQ_WIDTH-1:0]    seq, seq_n;
    byte_idx_t               byte_idx, idx_n;
    logic                    tvalid_n, tlast_n;
    logic [BYTE_WIDTH-1:0]   tdata_n;
    logic                    clear_c;
    logic                    v_full, c_full, v_take_c, c_take_c;
    logic [SAMPLE_WIDTH-1:0] v_data, c_data;
`ifdef XADC_PACKET_CHECKSUM_EN
    logic [BYTE_WIDTH-1:0]   csum, csum_n;
`endif

    axis_sample_hold #(.WIDTH(SAMPLE_WIDTH)) u_voltage_hold (
        .clk      (clk),
        .rst      (rst),
        .s_tvalid (voltage_tvalid),
        .s_tready (voltage_tready),
        .s_tdata  (voltage_tdata),
        .clear    (clear_c),
        .full     (v_full),
        .data     (v_data),
        .take_c   (v_take_c)
    );

    axis_sample_hold #(.WIDTH(SAMPLE_WIDTH)) u_current_hold (
        .clk      (clk),
        .rst      (rst),
        .s_tvalid (current_tvalid),
        .s_tready (current_tready),
        .s_tdata  (current_tdata),
        .clear    (clear_c),
        .full     (c_full),
        .data     (c_data),
        .take_c   (c_take_c)
    );

    assign packet_tkeep = 1'b1;
    assign packet_tid   = 1'b0;
    assign packet_tdest = 1'b0;
    assign packet_tuser = 1'b0;

    // Next-state and next-output: computes what the output registers hold next cycle.
    always_comb begin
        state_n  = state;
        seq_n    = seq;
        idx_n    = byte_idx;
        tvalid_n = packet_tvalid;
        tdata_n  = packet_tdata;
        tlast_n  = packet_tlast;
        clear_c  = 1'b0;
`ifdef XADC_PACKET_CHECKSUM_EN
        csum_n   = csum;
`endif
        case (state)
            COLLECT: begin
                if ((v_full | v_take_c) && (c_full | c_take_c)) begin
                    state_n  = SEND;
                    tvalid_n = 1'b1;
                    tdata_n  = seq;
                    tlast_n  = 1'b0;
                    idx_n    = '0;
`ifdef XADC_PACKET_CHECKSUM_EN
                    csum_n   = '0;
`endif
                end
            end
            SEND: begin
                if (packet_tready) begin
`ifdef XADC_PACKET_CHECKSUM_EN
                    csum_n = csum ^ packet_tdata;
`endif
                    if (byte_idx == LAST_IDX) begin
                        state_n  = COLLECT;
                        seq_n    = seq + SEQ_WIDTH'(1);
                        idx_n    = '0;
                        tvalid_n = 1'b0;
                        tdata_n  = '0;
                        tlast_n  = 1'b0;
                        clear_c  = 1'b1;
                    end else begin
                        idx_n   = byte_idx + byte_idx_t'(1);
                        tlast_n = (idx_n == LAST_IDX);
                        case (idx_n)
                            byte_idx_t'(1): tdata_n = v_data[SAMPLE_WIDTH-1 -: BYTE_WIDTH];
                            byte_idx_t'(2): tdata_n = v_data[BYTE_WIDTH-1:0];
                            byte_idx_t'(3): tdata_n = c_data[SAMPLE_WIDTH-1 -: BYTE_WIDTH];
                            byte_idx_t'(4): tdata_n = c_data[BYTE_WIDTH-1:0];
`ifdef XADC_PACKET_CHECKSUM_EN
                            byte_idx_t'(5): tdata_n = csum_n;
`endif
                            default:        tdata_n = '0;
                        endcase
                    end
                end
            end
            default: state_n = COLLECT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= COLLECT;
            seq           <= '0;
            byte_idx      <= '0;
            packet_tvalid <= 1'b0;
            packet_tdata  <= '0;
            packet_tlast  <= 1'b0;
`ifdef XADC_PACKET_CHECKSUM_EN
            csum          <= '0;
`endif
        end else begin
            state         <= state_n;
            seq           <= seq_n;
            byte_idx      <= idx_n;
            packet_tvalid <= tvalid_n;
            packet_tdata  <= tdata_n;
            packet_tlast  <= tlast_n;
`ifdef XADC_PACKET_CHECKSUM_EN
            csum          <= csum_n;
`endif
        end
    end

endmodule

// File: tb/tb_xadc_sample_packetizer.sv
// Directed and randomized bench for xadc_sample_packetizer against a queue-based packet model.
module tb_xadc_sample_packetizer;

`ifdef XADC_PACKET_CHECKSUM_EN
    localparam int PB = 6;
`else
    localparam int PB = 5;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        v_valid, v_ready, c_valid, c_ready;
    logic [15:0] v_data, c_data;
    logic        packet_tvalid, out_ready, packet_tlast;
    logic [7:0]  packet_tdata;
    logic        packet_tkeep, packet_tid, packet_tdest, packet_tuser;

    always #5 clk = ~clk;

    xadc_sample_packetizer dut (
        .clk            (clk),
        .rst            (rst),
        .voltage_tvalid (v_valid),
        .voltage_tready (v_ready),
        .voltage_tdata  (v_data),
        .current_tvalid (c_valid),
        .current_tready (c_ready),
        .current_tdata  (c_data),
        .packet_tvalid  (packet_tvalid),
        .packet_tready  (out_ready),
        .packet_tdata   (packet_tdata),
        .packet_tlast   (packet_tlast),
        .packet_tkeep   (packet_tkeep),
        .packet_tid     (packet_tid),
        .packet_tdest   (packet_tdest),
        .packet_tuser   (packet_tuser)
    );

    int          n_pass = 0;
    int          n_total = 0;
    logic [15:0] vq[$];
    logic [15:0] cq[$];
    int          out_count;
    int          pkts_done;
    logic        v_hs, c_hs, o_hs;
    logic [7:0]  last_tlast_byte;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total = n_total + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        vq.delete();
        cq.delete();
        out_count = 0;
        pkts_done = 0;
    endtask

    // Expected byte number idx of the stream since reset, straight from the packet layout.
    function automatic logic [7:0] exp_byte(input int idx);
        int          pkt;
        int          pos;
        logic [15:0] v;
        logic [15:0] c;
        logic [7:0]  s;
        pkt = idx / PB;
        pos = idx % PB;
        v = vq[pkt];
        c = cq[pkt];
        s = 8'(pkt % 256);
        case (pos)
            0:       return s;
            1:       return v[15:8];
            2:       return v[7:0];
            3:       return c[15:8];
            4:       return c[7:0];
            default: return s ^ v[15:8] ^ v[7:0] ^ c[15:8] ^ c[7:0];
        endcase
    endfunction

    // Checks the cycle's outputs against the model, then records the handshakes the next edge takes.
    task automatic monitor();
        bit v_empty;
        bit c_empty;
        bit exp_valid;
        v_empty   = (vq.size() == pkts_done);
        c_empty   = (cq.size() == pkts_done);
        exp_valid = !v_empty && !c_empty;
        check("voltage_tready", 32'(v_ready), 32'(v_empty));
        check("current_tready", 32'(c_ready), 32'(c_empty));
        check("tvalid", 32'(packet_tvalid), 32'(exp_valid));
        if (exp_valid) begin
            check("tdata", 32'(packet_tdata), 32'(exp_byte(out_count)));
            check("tlast", 32'(packet_tlast), 32'((out_count % PB) == PB - 1));
        end
        o_hs = packet_tvalid & out_ready;
        v_hs = v_valid & v_ready;
        c_hs = c_valid & c_ready;
        if (o_hs && exp_valid) begin
            if (packet_tlast) last_tlast_byte = packet_tdata;
            if ((out_count % PB) == PB - 1) pkts_done = pkts_done + 1;
            out_count = out_count + 1;
        end
        if (v_hs) vq.push_back(v_data);
        if (c_hs) cq.push_back(c_data);
    endtask

    task automatic cycle();
        #1;
        monitor();
        @(posedge clk);
        @(negedge clk);
        if (v_hs) v_valid = 1'b0;
        if (c_hs) c_valid = 1'b0;
    endtask

    // Supplies whichever channel is short so every accepted sample completes a packet.
    task automatic drain(input int budget);
        out_ready = 1'b1;
        for (int i = 0; i < budget; i++) begin
            if (!v_valid && (vq.size() < cq.size() + int'(c_valid))) begin
                v_valid = 1'b1;
                v_data  = 16'($urandom);
            end
            if (!c_valid && (cq.size() < vq.size() + int'(v_valid))) begin
                c_valid = 1'b1;
                c_data  = 16'($urandom);
            end
            cycle();
        end
        check("drained_voltage", 32'(vq.size()), 32'(pkts_done));
        check("drained_current", 32'(cq.size()), 32'(pkts_done));
    endtask

    initial begin
        int target;
        rst = 1'b1;
        v_valid = 1'b0; c_valid = 1'b0;
        v_data = '0; c_data = '0;
        out_ready = 1'b1;
        last_tlast_byte = '0;
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_tvalid", 32'(packet_tvalid), 0);
        check("rst_tdata", 32'(packet_tdata), 0);
        check("rst_tlast", 32'(packet_tlast), 0);
        check("rst_v_ready", 32'(v_ready), 0);
        check("rst_c_ready", 32'(c_ready), 0);
        check("tkeep", 32'(packet_tkeep), 1);
        check("tid_tdest_tuser", 32'({packet_tid, packet_tdest, packet_tuser}), 0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_v_ready", 32'(v_ready), 1);
        check("post_rst_c_ready", 32'(c_ready), 1);

        // Simultaneous arrival, one-cycle latency to byte0.
        v_valid = 1'b1; v_data = 16'h1234;
        c_valid = 1'b1; c_data = 16'hABC0;
        cycle();
        check("latency_tvalid", 32'(packet_tvalid), 1);
        check("latency_byte0", 32'(packet_tdata), 32'h00);
        repeat (8) cycle();
        check("last_byte_pkt0", 32'(last_tlast_byte), (PB == 6) ? 32'h4D : 32'hC0);
        v_valid = 1'b1; v_data = 16'h5555;
        c_valid = 1'b1; c_data = 16'h6666;
        cycle();
        check("seq1_byte0", 32'(packet_tdata), 32'h01);
        repeat (8) cycle();

        // Skewed arrival with a second voltage sample held back.
        v_valid = 1'b1; v_data = 16'h0FF0;
        cycle();
        v_valid = 1'b1; v_data = 16'h1111;
        repeat (3) cycle();
        c_valid = 1'b1; c_data = 16'h0008;
        repeat (12) cycle();
        check("skew_held_voltage", 32'(vq[vq.size() - 1]), 32'h1111);
        drain(14);

        // Random arrivals with a random downstream stall pattern.
        for (int i = 0; i < 600; i++) begin
            if (!v_valid && ($urandom_range(0, 3) != 0)) begin
                v_valid = 1'b1;
                v_data  = 16'($urandom);
            end
            if (!c_valid && ($urandom_range(0, 3) != 0)) begin
                c_valid = 1'b1;
                c_data  = 16'($urandom);
            end
            out_ready = 1'($urandom_range(0, 1));
            cycle();
        end
        drain(40);

        // Reset mid-packet: takes effect without a clock edge, seq restarts.
        v_valid = 1'b1; v_data = 16'h1234;
        c_valid = 1'b1; c_data = 16'hABC0;
        repeat (3) cycle();
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("midrst_tvalid", 32'(packet_tvalid), 0);
        check("midrst_tdata", 32'(packet_tdata), 0);
        check("midrst_tlast", 32'(packet_tlast), 0);
        check("midrst_ready", 32'({v_ready, c_ready}), 0);
        v_valid = 1'b0; c_valid = 1'b0;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        v_valid = 1'b1; v_data = 16'h1234;
        c_valid = 1'b1; c_data = 16'hABC0;
        cycle();
        check("midrst_seq0", 32'(packet_tdata), 32'h00);
        repeat (8) cycle();
        check("midrst_last_byte", 32'(last_tlast_byte), (PB == 6) ? 32'h4D : 32'hC0);

        // Sequence wrap across 257 back-to-back packets.
        target = pkts_done + 257;
        for (int i = 0; i < 257 * 8 && pkts_done < target; i++) begin
            if (!v_valid && (vq.size() < target)) begin
                v_valid = 1'b1;
                v_data  = 16'($urandom);
            end
            if (!c_valid && (cq.size() < target)) begin
                c_valid = 1'b1;
                c_data  = 16'($urandom);
            end
            cycle();
        end
        check("wrap_done", 32'(pkts_done >= target), 1);
        drain(10);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
